// File: rtl/ap_data_engine_if.sv
// rtl/ap_data_engine_if.sv - sequencer handshake and RAM port bundle for ap_data_engine
interface ap_data_engine_if #(
  parameter int AP_DIGITS   = 6,
  parameter int DATA_DIGITS = 3,
  parameter int ADDR_WIDTH  = 18
);
  logic                     ApRequest;
  logic                     DataRequest;
  logic                     Dec;
  logic                     Ready;
  logic                     ApZero;
  logic                     DataZero;
  logic [4*AP_DIGITS-1:0]   Address;
  logic [4*DATA_DIGITS-1:0] Data;
  logic [ADDR_WIDTH-1:0]    RamAddress;
  logic [4*DATA_DIGITS-1:0] RamDataIn;
  logic [4*DATA_DIGITS-1:0] RamDataOut;
  logic                     RamCS;
  logic                     RamWE;

  // Engine side: answers the sequencer and owns the RAM port.
  modport slave (
    input  ApRequest, DataRequest, Dec, RamDataOut,
    output Ready, ApZero, DataZero, Address, Data,
           RamAddress, RamDataIn, RamCS, RamWE
  );

  // Sequencer and RAM side.
  modport master (
    output ApRequest, DataRequest, Dec, RamDataOut,
    input  Ready, ApZero, DataZero, Address, Data,
           RamAddress, RamDataIn, RamCS, RamWE
  );
endinterface

// File: rtl/ap_data_engine.sv
// rtl/ap_data_engine.sv - BCD data pointer / cell engine; APDATA_RAM_CLEAR_EN enables the reset RAM sweep
module apDataEngineBcdStep #(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] value,
  input  logic                dec,
  output logic [4*DIGITS-1:0] result
);
  // carry[i] is the decimal carry/borrow flowing into digit i; digit 0 always steps.
  logic [DIGITS-1:0] carry;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : gDigit
    logic [3:0] d;
    logic       atEdge;
    assign d      = value[4*i +: 4];
    assign atEdge = dec ? (d == 4'd0) : (d == 4'd9);
    assign result[4*i +: 4] = !carry[i] ? d :
                              atEdge    ? (dec ? 4'd9 : 4'd0) :
                                          (dec ? d - 4'd1 : d + 4'd1);
    if (i < DIGITS - 1) begin : gCarry
      assign carry[i+1] = carry[i] & atEdge;
    end
  end
endmodule

module ap_data_engine #(
  parameter int AP_DIGITS   = 6,
  parameter int DATA_DIGITS = 3,
  parameter int ADDR_WIDTH  = 18
) (
  input logic              Clk,
  input logic              Rst,
  ap_data_engine_if.slave  apBus
);
  typedef enum logic [2:0] {
    IDLE,
    DATA_STEP,
    WRITEBACK,
    AP_STEP,
    READ,
    LATCH
`ifdef APDATA_RAM_CLEAR_EN
    , CLEAR
`endif
  } stateT;

  stateT                    state, stateNext;
  logic [4*AP_DIGITS-1:0]   apReg, apStepped;
  logic [4*DATA_DIGITS-1:0] dataReg, dataStepped;
  logic                     dirty;
  logic                     decLatch;
  logic                     ramCs, ramWe;
  logic [ADDR_WIDTH-1:0]    ramAddr;
  logic [4*DATA_DIGITS-1:0] ramData;
`ifdef APDATA_RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0]    clearAddr;
`endif

  apDataEngineBcdStep #(.DIGITS(AP_DIGITS)) uApStep (
    .value  (apReg),
    .dec    (decLatch),
    .result (apStepped)
  );

  apDataEngineBcdStep #(.DIGITS(DATA_DIGITS)) uDataStep (
    .value  (dataReg),
    .dec    (decLatch),
    .result (dataStepped)
  );

  // Next-state: requests only count in IDLE, and an AP move beats a data step.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (apBus.ApRequest)        stateNext = dirty ? WRITEBACK : AP_STEP;
        else if (apBus.DataRequest) stateNext = DATA_STEP;
      end
      DATA_STEP: stateNext = IDLE;
      WRITEBACK: stateNext = AP_STEP;
      AP_STEP:   stateNext = READ;
      READ:      stateNext = LATCH;
      LATCH:     stateNext = IDLE;
`ifdef APDATA_RAM_CLEAR_EN
      CLEAR:     if (&clearAddr) stateNext = IDLE;
`endif
      default:   stateNext = IDLE;
    endcase
  end

  // RAM strobes decode straight from the state; the address follows AP except while sweeping.
  always_comb begin
    ramCs   = 1'b0;
    ramWe   = 1'b0;
    ramAddr = apReg[ADDR_WIDTH-1:0];
    ramData = dataReg;
    case (state)
      WRITEBACK: begin
        ramCs = 1'b1;
        ramWe = 1'b1;
      end
      READ: ramCs = 1'b1;
`ifdef APDATA_RAM_CLEAR_EN
      CLEAR: begin
        ramCs   = 1'b1;
        ramWe   = 1'b1;
        ramAddr = clearAddr;
        ramData = '0;
      end
`endif
      default: ;
    endcase
  end

  // State, pointer, cell value and dirty tracking; reset aborts any move in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
`ifdef APDATA_RAM_CLEAR_EN
      state     <= CLEAR;
      clearAddr <= '0;
`else
      state     <= IDLE;
`endif
      apReg    <= '0;
      dataReg  <= '0;
      dirty    <= 1'b1;
      decLatch <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (apBus.ApRequest || apBus.DataRequest) decLatch <= apBus.Dec;
        end
        DATA_STEP: begin
          dataReg <= dataStepped;
          dirty   <= 1'b1;
        end
        WRITEBACK: dirty   <= 1'b0;
        AP_STEP:   apReg   <= apStepped;
        LATCH:     dataReg <= apBus.RamDataOut;
`ifdef APDATA_RAM_CLEAR_EN
        CLEAR: begin
          clearAddr <= clearAddr + 1'b1;
          if (&clearAddr) dirty <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign apBus.Ready      = (state == IDLE) & ~apBus.ApRequest & ~apBus.DataRequest;
  assign apBus.ApZero     = (apReg == '0);
  assign apBus.DataZero   = (dataReg == '0);
  assign apBus.Address    = apReg;
  assign apBus.Data       = dataReg;
  assign apBus.RamAddress = ramAddr;
  assign apBus.RamDataIn  = ramData;
  assign apBus.RamCS      = ramCs;
  assign apBus.RamWE      = ramWe;
endmodule

// File: tb/tb_ap_data_engine.sv
// tb/tb_ap_data_engine.sv - directed and random checks of ap_data_engine against an integer model
module tb_ap_data_engine;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  ap_data_engine_if #(.AP_DIGITS(6), .DATA_DIGITS(3), .ADDR_WIDTH(18)) bus ();

  ap_data_engine #(.AP_DIGITS(6), .DATA_DIGITS(3), .ADDR_WIDTH(18)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .apBus (bus)
  );

  function automatic logic [23:0] toBcd(input int v);
    logic [23:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    logic [23:0] t;
    t = toBcd(v);
    return t[11:0];
  endfunction

  function automatic int ramAddrOf(input int ap);
    logic [23:0] t;
    t = toBcd(ap);
    return int'({14'b0, t[17:0]});
  endfunction

  function automatic int initVal(input int a);
    return (a * 7 + 13) % 1000;
  endfunction

  // RAM environment: synchronous write, registered read.
  logic [11:0] ram [int];
  int          writeCount = 0;
  int          readCount  = 0;
  int          lastWAddr  = -1;
  logic [11:0] lastWData;

  always @(posedge Clk) begin
    int a;
    a = int'({14'b0, bus.RamAddress});
    if (bus.RamCS && bus.RamWE) begin
      ram[a]     = bus.RamDataIn;
      writeCount = writeCount + 1;
      lastWAddr  = a;
      lastWData  = bus.RamDataIn;
    end else if (bus.RamCS) begin
      readCount = readCount + 1;
      bus.RamDataOut <= ram.exists(a) ? ram[a] : bcd3(initVal(a));
    end
  end

  // Reference model, plain integers.
  int mAp, mData;
  bit mDirty;
  int modelMem [int];

  function automatic int memVal(input int a);
    return modelMem.exists(a) ? modelMem[a] : initVal(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    logic [23:0] b;
    b = toBcd(mAp);
    check({tag, "_addr"},    32'(bus.Address),    32'(b));
    check({tag, "_data"},    32'(bus.Data),       32'(bcd3(mData)));
    check({tag, "_apzero"},  32'(bus.ApZero),     32'(mAp == 0));
    check({tag, "_dzero"},   32'(bus.DataZero),   32'(mData == 0));
    check({tag, "_ramaddr"}, 32'(bus.RamAddress), 32'(ramAddrOf(mAp)));
    check({tag, "_ramdin"},  32'(bus.RamDataIn),  32'(bcd3(mData)));
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    mAp = 0; mData = 0; mDirty = 1'b1;
    check("reset_ready", 32'(bus.Ready), 32'd1);
    check("reset_cs",    32'(bus.RamCS), 32'd0);
    checkState("reset");
  endtask

  task automatic dataReq(input bit dec);
    int old;
    old = mData;
    @(negedge Clk);
    bus.DataRequest = 1'b1;
    bus.Dec = dec;
    #1 check("data_ready_drop", 32'(bus.Ready), 32'd0);
    @(negedge Clk);
    bus.DataRequest = 1'b0;
    bus.Dec = 1'b0;
    #1;
    check("data_busy",  32'(bus.Ready), 32'd0);
    check("data_held",  32'(bus.Data),  32'(bcd3(old)));
    mData  = dec ? (mData + 999) % 1000 : (mData + 1) % 1000;
    mDirty = 1'b1;
    @(negedge Clk);
    #1;
    check("data_ready_back", 32'(bus.Ready), 32'd1);
    checkState("data");
  endtask

  task automatic apReq(input bit dec, input bit alsoData, input bit busyPulse);
    int oldAp, wc, rc, lowCount, expLat;
    bit wasDirty;
    oldAp = mAp; wc = writeCount; rc = readCount; wasDirty = mDirty;
    expLat = wasDirty ? 4 : 3;
    @(negedge Clk);
    bus.ApRequest = 1'b1;
    bus.DataRequest = alsoData;
    bus.Dec = dec;
    #1 check("ap_ready_drop", 32'(bus.Ready), 32'd0);
    @(negedge Clk);
    bus.ApRequest = 1'b0;
    bus.DataRequest = 1'b0;
    bus.Dec = 1'b0;
    #1;
    check("ap_data_hold", 32'(bus.Data),  32'(bcd3(mData)));
    check("ap_cs_first",  32'(bus.RamCS), 32'(wasDirty));
    check("ap_we_first",  32'(bus.RamWE), 32'(wasDirty));
    lowCount = 0;
    while (!bus.Ready && lowCount < 10) begin
      lowCount++;
      bus.DataRequest = busyPulse && (lowCount == 1);
      @(negedge Clk);
      #1;
    end
    bus.DataRequest = 1'b0;
    if (wasDirty) modelMem[ramAddrOf(oldAp)] = mData;
    mDirty = 1'b0;
    mAp    = dec ? (mAp + 999999) % 1000000 : (mAp + 1) % 1000000;
    mData  = memVal(ramAddrOf(mAp));
    check("ap_latency", 32'(lowCount), 32'(expLat));
    check("ap_writes",  32'(writeCount - wc), wasDirty ? 32'd1 : 32'd0);
    if (wasDirty) begin
      check("ap_wb_addr", 32'(lastWAddr), 32'(ramAddrOf(oldAp)));
      check("ap_wb_data", 32'(lastWData), 32'(bcd3(modelMem[ramAddrOf(oldAp)])));
    end
    check("ap_reads", 32'(readCount - rc), 32'd1);
    checkState("ap");
  endtask

  initial begin
    int wc;
    bus.ApRequest   = 1'b0;
    bus.DataRequest = 1'b0;
    bus.Dec         = 1'b0;
    mAp = 0; mData = 0; mDirty = 1'b1;

    // Reset and three increments.
    doReset();
    for (int i = 0; i < 3; i++) dataReq(1'b0);

    // Data wrap both directions.
    doReset();
    dataReq(1'b1);
    dataReq(1'b0);

    // Data 042 written back on a pointer move, then a clean move.
    doReset();
    for (int i = 0; i < 42; i++) dataReq(1'b0);
    apReq(1'b0, 1'b0, 1'b0);
    apReq(1'b0, 1'b0, 1'b0);

    // Pointer wrap below zero.
    doReset();
    apReq(1'b1, 1'b0, 1'b0);
    check("wrap_ramaddr", 32'(bus.RamAddress), 32'h19999);

    // Simultaneous requests and a request while busy.
    dataReq(1'b0);
    apReq(1'b0, 1'b1, 1'b1);
    apReq(1'b1, 1'b1, 1'b1);

    // Reset in the middle of a pointer move.
    doReset();
    for (int i = 0; i < 5; i++) dataReq(1'b0);
    @(negedge Clk);
    bus.ApRequest = 1'b1;
    @(negedge Clk);
    bus.ApRequest = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    wc = writeCount;
    modelMem[ramAddrOf(mAp)] = mData;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    mAp = 0; mData = 0; mDirty = 1'b1;
    check("abort_ready",  32'(bus.Ready), 32'd1);
    check("abort_cs",     32'(bus.RamCS), 32'd0);
    check("abort_writes", 32'(writeCount - wc), 32'd0);
    checkState("abort");
    apReq(1'b0, 1'b0, 1'b0);
    apReq(1'b1, 1'b0, 1'b0);

    // Random operation mix.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: dataReq(1'b0);
        1: dataReq(1'b1);
        2: apReq(1'b0, 1'b0, 1'b0);
        3: apReq(1'b1, 1'b0, 1'b0);
        default: apReq(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
